hdmi_pixel_fetch: RTL and testbench

Frame read controller that sits directly upstream of the HDMI output stage. It fetches RGB565 pixels of one frame from the memory read port in fixed bursts into a local FIFO and answers the display stage's per-pixel read request (`rd_en`) with `rd_data` one cycle later. It restarts cleanly at every frame boundary signalled by `video_vs`, counts underflows, and runs entirely in the pixel clock domain.

---
 rtl/hdmi_pixel_fetch_if.sv | 22 ++
 rtl/hdmi_pixel_fetch.sv | 209 ++++++++++++++++++++
 tb/tb_hdmi_pixel_fetch.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_pixel_fetch_if.sv
// Memory read port between the pixel fetcher (master) and the frame memory (slave).
// One burst request at a time: req/addr/len held until ack, then len data beats.
interface hdmi_pixel_fetch_if #(
  parameter int ADDR_W = 22
) ();
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [7:0]        mem_rd_len;
  logic              mem_rd_ack;
  logic              mem_rd_valid;
  logic [15:0]       mem_rd_data;

  modport master (
    output mem_rd_req, mem_rd_addr, mem_rd_len,
    input  mem_rd_ack, mem_rd_valid, mem_rd_data
  );

  modport slave (
    input  mem_rd_req, mem_rd_addr, mem_rd_len,
    output mem_rd_ack, mem_rd_valid, mem_rd_data
  );
endinterface

// File: rtl/hdmi_pixel_fetch.sv
// Frame read controller feeding the HDMI output stage. Fetches RGB565 pixels in
// bursts into a local FIFO, serves per-pixel reads one cycle after rd_en, restarts
// at every rising edge of video_vs and counts reads that found the FIFO empty.
module hdmi_pixel_fetch #(
  parameter int          FIFO_DEPTH = 64,
  parameter int          BURST_LEN  = 16,
  parameter int          ADDR_W     = 22,
  parameter int unsigned BASE_ADDR  = 32'd0
) (
  input  logic        hdmi_clk,
  input  logic        rst_n,
  input  logic [10:0] h_disp,
  input  logic [10:0] v_disp,
  input  logic        video_vs,
  input  logic        rd_en,
  output logic [15:0] rd_data,
  output logic [15:0] underflow_cnt,
  hdmi_pixel_fetch_if.master mem
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [21:0]       BURST_MAX = 22'(BURST_LEN);
  localparam logic [15:0]       DEPTH16   = 16'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t            state, state_nxt;
  logic              vs_d, fs;
  logic              rd_req, rd_req_nxt;
  logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
  logic [7:0]        rd_len, rd_len_nxt;
  logic [7:0]        beats, beats_nxt;
  logic              stale, stale_nxt;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
  logic [21:0]       remaining, remaining_nxt;

  logic [15:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [21:0]       frame_size, eff_rem;
  logic [ADDR_W-1:0] eff_addr;
  logic [CNT_W-1:0]  eff_cnt;
  logic [7:0]        next_len;
  logic [15:0]       fill_after;
  logic              push, pop, underflow, last_beat;

  // Products of the sampled geometry never exceed 22 bits (2047*2047).
  assign frame_size = 22'(h_disp) * 22'(v_disp);
  // On a frame start the new frame's counters and an empty FIFO are used at once,
  // so the first request of a frame can go out the cycle after the flush.
  assign eff_rem    = fs ? frame_size : remaining;
  assign eff_addr   = fs ? BASE : cur_addr;
  assign eff_cnt    = fs ? CNT_W'(0) : count;
  assign next_len   = (eff_rem < BURST_MAX) ? eff_rem[7:0] : BURST_MAX[7:0];
  assign fill_after = 16'(eff_cnt) + 16'(next_len);

  assign push      = mem.mem_rd_valid && (state == WAIT) && !fs;
  assign pop       = rd_en && (count != CNT_W'(0)) && !fs;
  assign underflow = rd_en && ((count == CNT_W'(0)) || fs);
  assign last_beat = mem.mem_rd_valid && (beats == 8'd1);

  assign mem.mem_rd_req  = rd_req;
  assign mem.mem_rd_addr = rd_addr;
  assign mem.mem_rd_len  = rd_len;

  // Registered frame-start pulse from the rising edge of video_vs.
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= 1'b0;
      fs   <= 1'b0;
    end else begin
      vs_d <= video_vs;
      fs   <= video_vs & ~vs_d;
    end
  end

  // Burst controller state and request registers.
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_req    <= 1'b0;
      rd_addr   <= BASE;
      rd_len    <= 8'd0;
      beats     <= 8'd0;
      stale     <= 1'b0;
      cur_addr  <= BASE;
      remaining <= 22'd0;
    end else begin
      state     <= state_nxt;
      rd_req    <= rd_req_nxt;
      rd_addr   <= rd_addr_nxt;
      rd_len    <= rd_len_nxt;
      beats     <= beats_nxt;
      stale     <= stale_nxt;
      cur_addr  <= cur_addr_nxt;
      remaining <= remaining_nxt;
    end
  end

  // Next-state logic: issue on credit, hold until ack, collect or discard beats.
  always_comb begin
    state_nxt     = state;
    rd_req_nxt    = rd_req;
    rd_addr_nxt   = rd_addr;
    rd_len_nxt    = rd_len;
    beats_nxt     = beats;
    stale_nxt     = stale;
    cur_addr_nxt  = cur_addr;
    remaining_nxt = remaining;
    if (fs) begin
      remaining_nxt = frame_size;
      cur_addr_nxt  = BASE;
    end else begin
      remaining_nxt = remaining;
      cur_addr_nxt  = cur_addr;
    end
    case (state)
      IDLE: begin
        if ((eff_rem != 22'd0) && (fill_after <= DEPTH16)) begin
          rd_req_nxt  = 1'b1;
          rd_addr_nxt = eff_addr;
          rd_len_nxt  = next_len;
          stale_nxt   = 1'b0;
          state_nxt   = REQ;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        // A presented request cannot be withdrawn; a frame start while waiting
        // for ack turns the burst into one that is drained and dropped.
        if (mem.mem_rd_ack) begin
          rd_req_nxt = 1'b0;
          beats_nxt  = rd_len;
          stale_nxt  = 1'b0;
          state_nxt  = (stale || fs) ? DRAIN : WAIT;
        end else begin
          stale_nxt = stale | fs;
        end
      end
      WAIT, DRAIN: begin
        if (mem.mem_rd_valid) begin
          beats_nxt = beats - 8'd1;
        end else begin
          beats_nxt = beats;
        end
        if (last_beat) begin
          state_nxt = IDLE;
          if ((state == WAIT) && !fs) begin
            cur_addr_nxt  = cur_addr + ADDR_W'(rd_len);
            remaining_nxt = remaining - 22'(rd_len);
          end else begin
            cur_addr_nxt  = fs ? BASE : cur_addr;
            remaining_nxt = fs ? frame_size : remaining;
          end
        end else if (fs) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = state;
        end
      end
      default: begin
        state_nxt  = IDLE;
        rd_req_nxt = 1'b0;
      end
    endcase
  end

  // FIFO pointers and occupancy; a frame start empties the FIFO.
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (fs) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge hdmi_clk) begin
    if (push) fifo_mem[wr_ptr] <= mem.mem_rd_data;
  end

  // Pixel output register and saturating underflow counter.
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data       <= 16'h0000;
      underflow_cnt <= 16'h0000;
    end else begin
      if (rd_en) rd_data <= pop ? fifo_mem[rd_ptr] : 16'h0000;
      if (underflow && (underflow_cnt != 16'hFFFF)) underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hdmi_pixel_fetch.sv
// Directed bench for hdmi_pixel_fetch: a frame-memory responder (data = address),
// a queue-based reference model of the pixel stream and request sequence, and
// hand-computed checks on the scenarios of interest.
module tb_hdmi_pixel_fetch;
  localparam int BURST = 16;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] h_disp = 11'd0;
  logic [10:0] v_disp = 11'd0;
  logic        video_vs = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic [15:0] underflow_cnt;

  hdmi_pixel_fetch_if #(.ADDR_W(22)) mif ();

  hdmi_pixel_fetch #(.FIFO_DEPTH(DEPTH), .BURST_LEN(BURST), .ADDR_W(22), .BASE_ADDR(0)) dut (
    .hdmi_clk(clk), .rst_n(rst_n), .h_disp(h_disp), .v_disp(v_disp),
    .video_vs(video_vs), .rd_en(rd_en), .rd_data(rd_data),
    .underflow_cnt(underflow_cnt), .mem(mif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- memory responder ----------------
  int          ack_delay = 0;
  bit          gap_en = 1'b0;
  int          mstate = 0;
  int          dly = 0;
  int          mi = 0;
  int          mlen = 0;
  logic [21:0] maddr = 22'd0;
  bit          phase = 1'b0;

  initial begin
    mif.mem_rd_ack = 1'b0;
    mif.mem_rd_valid = 1'b0;
    mif.mem_rd_data = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      mif.mem_rd_ack = 1'b0;
      mif.mem_rd_valid = 1'b0;
      if (!rst_n) begin
        mstate = 0;
        dly = 0;
      end else if (mstate == 0) begin
        if (mif.mem_rd_req) begin
          if (dly >= ack_delay) begin
            mif.mem_rd_ack = 1'b1;
            maddr = mif.mem_rd_addr;
            mlen = int'(mif.mem_rd_len);
            mi = 0;
            dly = 0;
            phase = 1'b0;
            mstate = 1;
          end else begin
            dly++;
          end
        end else begin
          dly = 0;
        end
      end else begin
        if (!(gap_en && phase)) begin
          mif.mem_rd_valid = 1'b1;
          mif.mem_rd_data = maddr[15:0] + 16'(mi);
          mi++;
          if (mi == mlen) mstate = 0;
        end
        phase = ~phase;
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  logic [15:0] q[$];
  logic [15:0] exp_data = 16'h0000;
  logic [15:0] exp_uf = 16'h0000;
  bit          fs_pend = 1'b0, vs_prev = 1'b0, fs_c = 1'b0;
  bit          req_prev = 1'b0, ack_prev = 1'b0;
  int          frame_id = 0, cur_tag = -1, req_seen = 0, exp_rem = 0, el = 0;
  logic [21:0] exp_addr = 22'd0, last_addr = 22'd0;
  int          last_len = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_data = 16'h0000; exp_uf = 16'h0000;
      fs_pend = 1'b0; vs_prev = 1'b0; req_prev = 1'b0; ack_prev = 1'b0;
      exp_rem = 0; exp_addr = 22'd0; cur_tag = -1;
    end else begin
      check("rd_data", rd_data, exp_data);
      check("underflow_cnt", underflow_cnt, exp_uf);
      // frame start is active one cycle after video_vs is first seen high
      fs_c = fs_pend;
      fs_pend = video_vs && !vs_prev;
      vs_prev = video_vs;
      if (mif.mem_rd_req && (!req_prev || ack_prev)) begin
        el = (exp_rem < BURST) ? exp_rem : BURST;
        check("req_addr", mif.mem_rd_addr, exp_addr);
        check("req_len", mif.mem_rd_len, el);
        last_addr = mif.mem_rd_addr;
        last_len = int'(mif.mem_rd_len);
        exp_addr = exp_addr + 22'(el);
        exp_rem = exp_rem - el;
        cur_tag = frame_id;
        req_seen++;
      end else if (mif.mem_rd_req) begin
        check("req_hold_addr", mif.mem_rd_addr, last_addr);
      end
      if (rd_en) begin
        if (fs_c || q.size() == 0) begin
          exp_data = 16'h0000;
          if (exp_uf != 16'hFFFF) exp_uf = exp_uf + 16'd1;
        end else begin
          exp_data = q.pop_front();
        end
      end
      if (mif.mem_rd_valid && !fs_c && cur_tag == frame_id) begin
        q.push_back(mif.mem_rd_data);
        check("fifo_no_overflow", q.size() <= DEPTH, 1);
      end
      if (fs_c) begin
        q.delete();
        frame_id++;
        exp_addr = 22'd0;
        exp_rem = int'(h_disp) * int'(v_disp);
      end
      req_prev = mif.mem_rd_req;
      ack_prev = mif.mem_rd_ack;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic frame_start(input int h, input int v);
    h_disp = 11'(h);
    v_disp = 11'(v);
    video_vs = 1'b1;
    step(1);
    video_vs = 1'b0;
  endtask

  task automatic pop_and_check(input int n, input int first, input string name);
    for (int i = 0; i <= n; i++) begin
      rd_en = (i < n);
      @(negedge clk);
      if (i > 0) check(name, rd_data, 32'(first + i - 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_req(input int target, input string name);
    int k = 0;
    while (req_seen < target && k < 500) begin
      step(1);
      k++;
    end
    check(name, req_seen >= target, 1);
  endtask

  task automatic check_reset_values();
    check("rst_rd_data", rd_data, 16'h0000);
    check("rst_req", mif.mem_rd_req, 1'b0);
    check("rst_addr", mif.mem_rd_addr, 22'd0);
    check("rst_len", mif.mem_rd_len, 8'd0);
    check("rst_underflow", underflow_cnt, 16'h0000);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;
  int k;

  initial begin
    // reset and idle
    step(3);
    check_reset_values();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rd_en = (i % 2 == 0);
      step(1);
    end
    rd_en = 1'b0;
    step(20);
    check("idle_underflow", underflow_cnt, 16'd3);
    check("idle_no_req", req_seen, 0);
    check("idle_rd_data", rd_data, 16'h0000);

    // two full bursts: 8x4 frame, data = address
    base = req_seen;
    frame_start(8, 4);
    step(100);
    check("two_bursts_reqs", req_seen - base, 2);
    check("two_bursts_last_addr", last_addr, 22'd16);
    pop_and_check(32, 0, "stream_0_31");
    check("stream_underflow", underflow_cnt, 16'd3);

    // short last burst: 5x3 frame -> single request of 15
    base = req_seen;
    frame_start(5, 3);
    step(80);
    check("short_reqs", req_seen - base, 1);
    check("short_len", last_len, 15);
    check("short_addr", last_addr, 22'd0);
    step(50);
    check("short_no_more", req_seen - base, 1);

    // FIFO fill limit with no reads
    base = req_seen;
    frame_start(640, 480);
    step(200);
    check("fill_reqs", req_seen - base, 4);
    pop_and_check(15, 0, "fill_pop");
    step(60);
    check("fill_15_pops_no_req", req_seen - base, 4);
    pop_and_check(1, 15, "fill_pop16");
    step(100);
    check("fill_fifth_req", req_seen - base, 5);

    // frame start mid-burst
    ack_delay = 1;
    gap_en = 1'b1;
    base = req_seen;
    frame_start(640, 480);
    wait_req(base + 1, "mid_first_req");
    step(45);
    pop_and_check(2, 0, "mid_pre_pop");
    k = 0;
    while (!(mstate == 1 && mi == 5) && k < 300) begin
      step(1);
      k++;
    end
    check("mid_reached_5_beats", (mstate == 1 && mi == 5), 1);
    video_vs = 1'b1;
    step(1);
    video_vs = 1'b0;
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    step(1);
    check("mid_flush_underflow", underflow_cnt, 16'd4);
    check("mid_flush_rd_data", rd_data, 16'h0000);
    base = req_seen;
    wait_req(base + 1, "mid_new_req");
    check("mid_new_addr", last_addr, 22'd0);
    check("mid_new_len", last_len, 16);
    step(45);
    pop_and_check(2, 0, "mid_first_pixels");
    check("mid_underflow_held", underflow_cnt, 16'd4);

    // reset, then underflow saturation
    rst_n = 1'b0;
    step(2);
    check_reset_values();
    rst_n = 1'b1;
    ack_delay = 0;
    gap_en = 1'b0;
    rd_en = 1'b1;
    step(65540);
    rd_en = 1'b0;
    step(2);
    check("sat_underflow", underflow_cnt, 16'hFFFF);
    check("sat_rd_data", rd_data, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
